axi_lite_slv_regs: RTL
======================

# axi_lite_slv_regs

AXI4-Lite responder exposing the accelerator's control/status register file to the host-side initiator. It decodes word-aligned accesses into NUM_RW read/write control registers and NUM_RO read-only status registers. Write and read channels run independent state machines, so one write and one read can be outstanding at the same time. Control registers drive the accelerator core directly; status registers are sampled from core outputs.

## Interface
- C_S_AXI_ADDR_WIDTH, 32, AXI address width
- C_S_AXI_DATA_WIDTH, 32, AXI data width; 32 or 64 only
- NUM_RW, 4, control registers at word indices 0..NUM_RW-1
- NUM_RO, 4, status registers at word indices NUM_RW..NUM_RW+NUM_RO-1
- One clock ACLK; reset ARESET is synchronous and active-high.
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data
- S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
- S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
- ctrl_regs  out  NUM_RW*C_S_AXI_DATA_WIDTH  control register contents, register i at slice i
- status_regs  in  NUM_RO*C_S_AXI_DATA_WIDTH  status inputs, slice j maps to index NUM_RW+j
- reg_wr_strobe  out  NUM_RW  one-cycle pulse on bit i when control register i is written

## Operation
- Decode:
  - ADDR_LSB = log2(C_S_AXI_DATA_WIDTH/8).
  - Index = addr >> ADDR_LSB.
  - Low ADDR_LSB bits are ignored.
  - Index ≥ NUM_RW+NUM_RO is out of range.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: AW and W are accepted independently and in either order, each into its own holding register.
    - AWREADY = ~aw_held; WREADY = ~w_held.
    - Commit happens on the edge where the later of the two handshakes completes, or where both complete together.
  - Commit to index < NUM_RW: byte lane k of that register is updated only where WSTRB[k]=1; BRESP=OKAY (2'b00).
  - Commit to a status index or an out-of-range index: no register changes, no strobe, BRESP=SLVERR (2'b10).
  - WSTRB=0 to a valid RW index: register unchanged, OKAY, strobe still pulses.
  - W_RESP: BVALID=1, AWREADY=WREADY=0. On BVALID&BREADY, clear the held flags and return to W_IDLE.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: ARREADY=1.
  - On AR handshake, register RDATA and RRESP and enter R_DATA.
    - RW index: current ctrl register value, OKAY.
    - RO index: status_regs slice sampled at that edge, OKAY.
    - Out of range: RDATA=0, SLVERR.
  - R_DATA: RVALID=1, ARREADY=0, RDATA/RRESP held stable. On RVALID&RREADY, return to R_IDLE.
- Read and write of the same RW register on the same edge: the read returns the pre-write value.

## Timing
- Reset values:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0.
  - BRESP, RRESP, RDATA = 0.
  - ctrl_regs = 0; reg_wr_strobe = 0.
  - Holding registers are cleared.
- AWREADY, WREADY and ARREADY rise on the first edge with ARESET low.
- Write latency: BVALID rises the cycle after the commit edge. reg_wr_strobe[i] is high that same cycle only. ctrl_regs shows the new value that same cycle.
- Read latency: RVALID rises the cycle after the AR handshake.
- Readies deassert on the cycle after the handshake. At BREADY=RREADY=1, peak throughput is one write per 2 cycles and one read per 2 cycles.
- BVALID/RVALID stay asserted until accepted, with unlimited back-pressure. Response data never changes while valid.
- ARESET mid-transaction aborts everything to reset values. Held AW/W are discarded and pending responses are dropped without handshake.

## Structure
- Shared package axi_lite_pkg:
  - RESP_OKAY, RESP_SLVERR.
  - W_IDLE/W_RESP and R_IDLE/R_DATA encodings.
  - addr_lsb() function for ADDR_LSB.
  - Reused by the existing initiator.
- One sub-module, axi_lite_addr_dec: combinational address→{index, is_rw, is_ro, err} decoder, instantiated once for the write path and once for the read path.

## Test plan
- Reset release: all readies 1 on the first edge with ARESET low; all valids 0; ctrl_regs all 0.
- AW at 0x4 in cycle 0, then W 0xDEADBEEF with WSTRB=4'hF in cycle 3:
  - BVALID in cycle 4 with BRESP=00.
  - reg_wr_strobe=4'b0010 in cycle 4.
  - Read of 0x4 returns 0xDEADBEEF, OKAY.
- Byte enables: reg 0 = 0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 → reg 0 = 0x11BB33DD.
- Errors:
  - Write to 0x10 (status index 4): BRESP=10, ctrl_regs unchanged, no strobe.
  - Read of 0x20: RDATA=0, RRESP=10.
  - Read of 0x14 with status_regs slice 1 = 0xCAFE0001: returns 0xCAFE0001, RRESP=00.
- Back-pressure: BREADY/RREADY held low for 10 cycles → BVALID/RVALID/data stable, all readies 0; accept on cycle 11 → readies return to 1 the next cycle.
- ARESET pulse while in W_RESP with a read in R_DATA: next cycle BVALID=RVALID=0 and ctrl_regs=0; a new write afterwards completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM encodings
// and the byte-offset width helper used by responders and initiators.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   // Number of address bits that select a byte within one data word
   function automatic int unsigned addr_lsb(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/axi_lite_addr_dec.sv
// Word-index decoder for the register file: splits an AXI address
// into control, status or out-of-range regions.
module axi_lite_addr_dec
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int NUM_RW = 4,
   parameter int NUM_RO = 4,
   localparam int NREG  = NUM_RW + NUM_RO,
   localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [IDX_W-1:0]  idx,
   output logic              is_rw,
   output logic              is_ro,
   output logic              err
);

   localparam int ALSB = addr_lsb(DATA_W);

   logic [ADDR_W-1:0] word;

   assign word  = addr >> ALSB;
   assign is_rw = (word < ADDR_W'(NUM_RW));
   assign is_ro = ~is_rw & (word < ADDR_W'(NREG));
   assign err   = ~(is_rw | is_ro);
   assign idx   = word[IDX_W-1:0];

endmodule

// File: rtl/axi_lite_slv_regs.sv
// AXI4-Lite responder for the accelerator control/status registers.
// Write and read channels run independent FSMs.
module axi_lite_slv_regs
   import axi_lite_pkg::*;
#(
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int NUM_RW             = 4,
   parameter int NUM_RO             = 4
) (
   input  logic                                 ACLK,
   input  logic                                 ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
   input  logic [2:0]                           S_AXI_AWPROT,
   input  logic                                 S_AXI_AWVALID,
   output logic                                 S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
   input  logic                                 S_AXI_WVALID,
   output logic                                 S_AXI_WREADY,
   output logic [1:0]                           S_AXI_BRESP,
   output logic                                 S_AXI_BVALID,
   input  logic                                 S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
   input  logic [2:0]                           S_AXI_ARPROT,
   input  logic                                 S_AXI_ARVALID,
   output logic                                 S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
   output logic [1:0]                           S_AXI_RRESP,
   output logic                                 S_AXI_RVALID,
   input  logic                                 S_AXI_RREADY,
   output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
   input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0] status_regs,
   output logic [NUM_RW-1:0]                    reg_wr_strobe
);

   localparam int AW    = C_S_AXI_ADDR_WIDTH;
   localparam int DW    = C_S_AXI_DATA_WIDTH;
   localparam int SW    = DW / 8;
   localparam int NREG  = NUM_RW + NUM_RO;
   localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

   wr_state_e w_state, w_next;
   rd_state_e r_state, r_next;

   logic           alive;
   logic           aw_held, w_held;
   logic [AW-1:0]  aw_addr;
   logic [DW-1:0]  w_data;
   logic [SW-1:0]  w_strb;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;

   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic [SW-1:0]    wr_strb;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic             wr_is_rw, wr_is_ro, wr_err;
   logic             rd_is_rw, rd_is_ro, rd_err;

   logic [DW-1:0]     regs [NUM_RW];
   logic [NUM_RW-1:0] strobe;
   logic [1:0]        bresp_q, rresp_q;
   logic [DW-1:0]     rdata_q;
   logic [DW-1:0]     rd_val;
   logic [1:0]        rd_resp;

   logic unused;
   assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_is_ro, wr_err, rd_err};

   assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
   assign b_hs  = S_AXI_BVALID & S_AXI_BREADY;
   assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
   assign r_hs  = S_AXI_RVALID & S_AXI_RREADY;

   // Commit fires on the edge that completes the later of AW and W
   assign commit = (w_state == W_IDLE)
                 & (aw_held | aw_hs)
                 & (w_held | w_hs);

   assign wr_addr = aw_held ? aw_addr : S_AXI_AWADDR;
   assign wr_data = w_held ? w_data : S_AXI_WDATA;
   assign wr_strb = w_held ? w_strb : S_AXI_WSTRB;

   axi_lite_addr_dec #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .NUM_RW (NUM_RW),
      .NUM_RO (NUM_RO)
   ) u_wr_dec (
      .addr  (wr_addr),
      .idx   (wr_idx),
      .is_rw (wr_is_rw),
      .is_ro (wr_is_ro),
      .err   (wr_err)
   );

   axi_lite_addr_dec #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .NUM_RW (NUM_RW),
      .NUM_RO (NUM_RO)
   ) u_rd_dec (
      .addr  (S_AXI_ARADDR),
      .idx   (rd_idx),
      .is_rw (rd_is_rw),
      .is_ro (rd_is_ro),
      .err   (rd_err)
   );

   // Keeps all readies low while reset is held
   always_ff @(posedge ACLK) begin
      if (ARESET) alive <= 1'b0;
      else        alive <= 1'b1;
   end

   // Write FSM state register
   always_ff @(posedge ACLK) begin
      if (ARESET) w_state <= W_IDLE;
      else        w_state <= w_next;
   end

   // Write FSM next state
   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE: if (commit) w_next = W_RESP;
         W_RESP: if (b_hs)   w_next = W_IDLE;
      endcase
   end

   // Write channel handshake outputs
   always_comb begin
      S_AXI_AWREADY = alive & (w_state == W_IDLE) & ~aw_held;
      S_AXI_WREADY  = alive & (w_state == W_IDLE) & ~w_held;
      S_AXI_BVALID  = (w_state == W_RESP);
   end

   // AW and W holding registers, released by the B handshake
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         aw_addr <= '0;
         w_data  <= '0;
         w_strb  <= '0;
      end else if (b_hs) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_held <= 1'b1;
            aw_addr <= S_AXI_AWADDR;
         end
         if (w_hs) begin
            w_held <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
      end
   end

   // Control register update, write strobe and write response
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < NUM_RW; i++) regs[i] <= '0;
         strobe  <= '0;
         bresp_q <= '0;
      end else begin
         strobe <= '0;
         if (commit) begin
            bresp_q <= wr_is_rw ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_RW; i++) begin
               if (wr_is_rw && wr_idx == IDX_W'(i)) begin
                  strobe[i] <= 1'b1;
                  for (int k = 0; k < SW; k++) begin
                     if (wr_strb[k])
                        regs[i][k*8 +: 8] <= wr_data[k*8 +: 8];
                  end
               end
            end
         end
      end
   end

   // Read FSM state register
   always_ff @(posedge ACLK) begin
      if (ARESET) r_state <= R_IDLE;
      else        r_state <= r_next;
   end

   // Read FSM next state
   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE: if (ar_hs) r_next = R_DATA;
         R_DATA: if (r_hs)  r_next = R_IDLE;
      endcase
   end

   // Read channel handshake outputs
   always_comb begin
      S_AXI_ARREADY = alive & (r_state == R_IDLE);
      S_AXI_RVALID  = (r_state == R_DATA);
   end

   // Read mux over control and status registers
   always_comb begin
      rd_val  = '0;
      rd_resp = RESP_SLVERR;
      if (rd_is_rw) begin
         rd_resp = RESP_OKAY;
         for (int i = 0; i < NUM_RW; i++)
            if (rd_idx == IDX_W'(i)) rd_val = regs[i];
      end else if (rd_is_ro) begin
         rd_resp = RESP_OKAY;
         for (int j = 0; j < NUM_RO; j++)
            if (rd_idx == IDX_W'(NUM_RW + j))
               rd_val = status_regs[j*DW +: DW];
      end
   end

   // Read data captured at the AR handshake and held while valid
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rdata_q <= '0;
         rresp_q <= '0;
      end else if (ar_hs) begin
         rdata_q <= rd_val;
         rresp_q <= rd_resp;
      end
   end

   for (genvar i = 0; i < NUM_RW; i++) begin : g_ctrl
      assign ctrl_regs[i*DW +: DW] = regs[i];
   end

   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign reg_wr_strobe = strobe;

endmodule
